// File: rtl/sw_step_pkg.sv
// Shared types for the switch step sequencer: FSM states, switch codes and
// small pattern helpers used by sw_step_controller.
package sw_step_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ISSUE,
    REJECT,
    RELEASE
  } state_t;

  localparam logic [1:0] CODE_SW0 = 2'b00;
  localparam logic [1:0] CODE_SW1 = 2'b01;
  localparam logic [1:0] CODE_SW2 = 2'b10;
  localparam logic [1:0] CODE_SW3 = 2'b11;

  function automatic logic is_one_hot(input logic [3:0] p);
    return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
  endfunction

  // x = sw3|sw2, y = sw3|sw1; only meaningful for a one-hot pattern.
  function automatic logic [1:0] encode_sw(input logic [3:0] p);
    return {p[3] | p[2], p[3] | p[1]};
  endfunction

endpackage

// File: rtl/sw_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous levels,
// cleared asynchronously by an active-low reset.
module sw_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      q        <= '0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/sw_step_controller.sv
// Debounces four step switches and issues a single-cycle step enable with the
// encoded switch code. Define SW_STEP_COUNT_EN to build the issued-step counter.
module sw_step_controller
  import sw_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] sw,
  output logic       step,
  output logic [1:0] code,
  output logic       busy,
  output logic       conflict,
  output logic [7:0] step_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sw_s;
  state_t           state_reg, state_next;
  logic [3:0]       pat_reg, pat_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       code_reg, code_next;

  sw_sync #(.W(4)) u_sync (
    .clk  (CLOCK_50),
    .rst_n(RESET_N),
    .d    (sw),
    .q    (sw_s)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= IDLE;
      pat_reg   <= '0;
      cnt_reg   <= '0;
      code_reg  <= CODE_SW0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    cnt_next   = cnt_reg;
    code_next  = code_reg;
    case (state_reg)
      IDLE: begin
        if (sw_s != 4'd0) begin
          pat_next   = sw_s;
          cnt_next   = '0;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (sw_s != pat_reg) begin
          if (sw_s == 4'd0) begin
            state_next = IDLE;
          end else begin
            pat_next = sw_s;
            cnt_next = '0;
          end
        end else if (cnt_reg == CNT_LAST) begin
          // Load the code on entry so it is already valid while step is high.
          if (is_one_hot(pat_reg)) begin
            state_next = ISSUE;
            code_next  = encode_sw(pat_reg);
          end else begin
            state_next = REJECT;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ISSUE, REJECT: begin
        cnt_next   = '0;
        state_next = RELEASE;
      end
      RELEASE: begin
        if (sw_s != 4'd0) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign step     = (state_reg == ISSUE);
  assign conflict = (state_reg == REJECT);
  assign busy     = (state_reg != IDLE);
  assign code     = code_reg;

`ifdef SW_STEP_COUNT_EN
  logic [7:0] step_cnt_reg;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      step_cnt_reg <= 8'd0;
    end else if (state_reg == ISSUE) begin
      step_cnt_reg <= step_cnt_reg + 8'd1;
    end
  end

  assign step_cnt = step_cnt_reg;
`else
  assign step_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sw_step_controller.sv
// Randomized and directed bench for sw_step_controller with DEBOUNCE_CYCLES=4,
// compared every cycle against an event-level model of press/release runs.
module tb_sw_step_controller;

  localparam int D = 4;

`ifdef SW_STEP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       step;
  logic [1:0] code;
  logic       busy;
  logic       conflict;
  logic [7:0] step_cnt;

  always #5 clk = ~clk;

  sw_step_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(2)) dut (
    .CLOCK_50(clk),
    .RESET_N (rst_n),
    .sw      (sw),
    .step    (step),
    .code    (code),
    .busy    (busy),
    .conflict(conflict),
    .step_cnt(step_cnt)
  );

  int checks = 0;
  int errors = 0;
  int n_steps = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sw delayed two edges, then run-length rules on samples.
  // phase 0 = waiting for a stable press, 1 = pulse cycle, 2 = waiting for release.
  logic [3:0] m_s1, m_s2, m_last, m_pulse;
  int         m_phase, m_run, m_zeros;
  logic [1:0] m_code;
  logic [7:0] m_cnt;

  function automatic logic onehot(input logic [3:0] p);
    return $countones(p) == 1;
  endfunction

  function automatic logic [1:0] bit_index(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_last = 0; m_pulse = 0;
    m_phase = 0; m_run = 0; m_zeros = 0;
    m_code = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [3:0] v;
    v = m_s2;
    m_s2 = m_s1;
    m_s1 = sw;
    case (m_phase)
      0: begin
        if (v == 4'd0) m_run = 0;
        else if (m_run > 0 && v == m_last) m_run++;
        else begin
          m_run = 1;
          m_last = v;
        end
        if (m_run == D + 1) begin
          m_phase = 1;
          m_pulse = m_last;
          if (onehot(m_last)) m_code = bit_index(m_last);
        end
      end
      1: begin
        if (onehot(m_pulse) && CNT_EN) m_cnt = m_cnt + 8'd1;
        m_phase = 2;
        m_zeros = 0;
      end
      default: begin
        if (v != 4'd0) m_zeros = 0;
        else m_zeros++;
        if (m_zeros == D) begin
          m_phase = 0;
          m_run = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("step", step, (m_phase == 1) && onehot(m_pulse));
    check("conflict", conflict, (m_phase == 1) && !onehot(m_pulse));
    check("code", code, m_code);
    check("busy", busy, (m_phase != 0) || (m_run > 0));
    check("step_cnt", step_cnt, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    if (step) n_steps++;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Counts edges from now until step (or conflict) is seen; -1 on timeout.
  task automatic measure(input string tag, input bit want_conflict, input int exp_lat);
    int lat;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((want_conflict ? conflict : step) && lat < 0) begin
        lat = i;
        break;
      end
    end
    check(tag, lat, exp_lat);
  endtask

  initial begin
    int s0;
    model_reset();
    #1;
    compare_all();
    check("rst_busy", busy, 0);
    ticks(3);
    rst_n = 1'b1;
    ticks(3);

    // Clean press of sw[2]
    s0 = n_steps;
    sw = 4'b0100;
    measure("clean_lat", 1'b0, 7);
    check("clean_code", code, 2'b10);
    ticks(13);
    sw = 4'b0000;
    ticks(12);
    check("clean_steps", n_steps - s0, 1);
    check("clean_busy", busy, 0);
    check("clean_cnt", step_cnt, CNT_EN ? 8'd1 : 8'd0);

    // Bouncing sw[1]
    s0 = n_steps;
    for (int k = 0; k < 5; k++) begin
      sw = 4'b0010; ticks(2);
      sw = 4'b0000; ticks(2);
    end
    sw = 4'b0010;
    measure("bounce_lat", 1'b0, 7);
    check("bounce_code", code, 2'b01);
    ticks(10);
    sw = 4'b0000;
    ticks(12);
    check("bounce_steps", n_steps - s0, 1);

    // Conflict then sw[3] alone
    s0 = n_steps;
    sw = 4'b1001;
    measure("conflict_lat", 1'b1, 7);
    check("conflict_code", code, 2'b01);
    ticks(5);
    sw = 4'b0000;
    ticks(12);
    check("conflict_steps", n_steps - s0, 0);
    sw = 4'b1000;
    measure("sw3_lat", 1'b0, 7);
    check("sw3_code", code, 2'b11);
    sw = 4'b0000;
    ticks(12);

    // Long hold of sw[0], then a second press
    s0 = n_steps;
    sw = 4'b0001;
    ticks(100);
    sw = 4'b0000;
    ticks(12);
    check("held_steps", n_steps - s0, 1);
    check("held_code", code, 2'b00);
    sw = 4'b0001;
    ticks(10);
    sw = 4'b0000;
    ticks(12);
    check("held_steps2", n_steps - s0, 2);

    // Reset during SETTLE with sw[2] still held
    sw = 4'b0100;
    ticks(4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_step", step, 0);
    check("rst_code", code, 0);
    check("rst_busy2", busy, 0);
    check("rst_conflict", conflict, 0);
    check("rst_cnt", step_cnt, 0);
    ticks(2);
    rst_n = 1'b1;
    measure("rst_lat", 1'b0, 7);
    sw = 4'b0000;
    ticks(12);

    // Randomized segments
    for (int seg = 0; seg < 300; seg++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) sw = 4'b0001 << $urandom_range(0, 3);
      else if (r < 8) sw = 4'b0000;
      else sw = 4'($urandom_range(0, 15));
      ticks($urandom_range(1, 12));
    end
    sw = 4'b0000;
    ticks(12);

    // Counter wrap from a fresh reset
    rst_n = 1'b0;
    #1;
    model_reset();
    ticks(2);
    rst_n = 1'b1;
    for (int p = 1; p <= 256; p++) begin
      sw = 4'b0001 << $urandom_range(0, 3);
      ticks(10);
      sw = 4'b0000;
      ticks(10);
      if (p == 255) check("cnt_255", step_cnt, CNT_EN ? 8'd255 : 8'd0);
    end
    check("cnt_wrap", step_cnt, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
